// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath: next-PC select
// encodings, primary opcodes and the default datapath width.
package mc_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      PCSRC_ULA    = 2'b00,
      PCSRC_ULAOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_HOLD   = 2'b11
   } pcsrc_t;

   localparam logic [5:0] R_TYPE = 6'b000000;
   localparam logic [5:0] LW     = 6'b100011;
   localparam logic [5:0] SW     = 6'b101011;
   localparam logic [5:0] BEQ    = 6'b000100;
   localparam logic [5:0] ADDI   = 6'b001000;
   localparam logic [5:0] J      = 6'b000010;

endpackage

// File: rtl/mc_en_reg.sv
// Enabled flop with asynchronous active-low reset to a parameterised value.
// Used for the PC, the IR and the free-running operand latches.
module mc_en_reg
   import mc_pkg::*;
#(
   parameter int           W       = WIDTH,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         o_q <= RST_VAL;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle MIPS datapath register bank: PC, IR, MDR, A/B, ULAOut, address
// mux, instruction field decode, retired-instruction counter, misaligned-PC flag.
module mc_datapath_regs
   import mc_pkg::*;
#(
   parameter int               WIDTH    = mc_pkg::WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IRWrite,
   input  logic             PCWrite,
   input  logic             Branch,
   input  logic             IorD,
   input  logic [1:0]       PCSrc,
   input  logic             Zero,
   input  logic [WIDTH-1:0] ULAResult,
   input  logic [WIDTH-1:0] MemRData,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] Instr,
   output logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] ULAOut,
   output logic [WIDTH-1:0] MemAdr,
   output logic [5:0]       Op,
   output logic [5:0]       Funct,
   output logic [4:0]       Rs,
   output logic [4:0]       Rt,
   output logic [4:0]       Rd,
   output logic [WIDTH-1:0] SignImm,
   output logic [WIDTH-1:0] SignImmSh,
   output logic [WIDTH-1:0] JumpTarget,
   output logic [31:0]      InstRet,
   output logic             PCMisaligned
);

   localparam int N_LAT = 4;

   logic                       w_pc_en;
   logic                       w_pc_load;
   logic [WIDTH-1:0]           w_pc_next;
   logic [WIDTH-1:0]           r_pc;
   logic [WIDTH-1:0]           r_instr;
   logic [N_LAT-1:0][WIDTH-1:0] w_lat_d;
   logic [N_LAT-1:0][WIDTH-1:0] w_lat_q;
   logic [31:0]                r_instret;
   logic                       r_pc_mis;

   assign w_pc_en = PCWrite | (Branch & Zero);

   always_comb begin
      w_pc_next = r_pc;
      case (pcsrc_t'(PCSrc))
         PCSRC_ULA:    w_pc_next = ULAResult;
         PCSRC_ULAOUT: w_pc_next = w_lat_q[3];
         PCSRC_JUMP:   w_pc_next = JumpTarget;
         default:      w_pc_next = r_pc;
      endcase
   end

   // HOLD is a true no-op: it must not count as a retired PC update.
   assign w_pc_load = w_pc_en & (pcsrc_t'(PCSrc) != PCSRC_HOLD);

   mc_en_reg #(.W(WIDTH), .RST_VAL(RESET_PC)) u_pc (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_pc_load),
      .i_d  (w_pc_next),
      .o_q  (r_pc)
   );

   mc_en_reg #(.W(WIDTH), .RST_VAL('0)) u_ir (
      .clk  (clk),
      .rst  (rst),
      .i_en (IRWrite),
      .i_d  (MemRData),
      .o_q  (r_instr)
   );

   // Slots: 0 = Data, 1 = A, 2 = B, 3 = ULAOut.
   assign w_lat_d = {ULAResult, RD2, RD1, MemRData};

   generate
      for (genvar gi = 0; gi < N_LAT; gi++) begin : g_lat
         mc_en_reg #(.W(WIDTH), .RST_VAL('0)) u_lat (
            .clk  (clk),
            .rst  (rst),
            .i_en (1'b1),
            .i_d  (w_lat_d[gi]),
            .o_q  (w_lat_q[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instret <= '0;
         r_pc_mis  <= 1'b0;
      end else if (w_pc_load) begin
         r_instret <= r_instret + 32'd1;
         r_pc_mis  <= r_pc_mis | (|w_pc_next[1:0]);
      end
   end

   assign PC           = r_pc;
   assign Instr        = r_instr;
   assign Data         = w_lat_q[0];
   assign A            = w_lat_q[1];
   assign B            = w_lat_q[2];
   assign ULAOut       = w_lat_q[3];
   assign MemAdr       = IorD ? w_lat_q[3] : r_pc;
   assign Op           = r_instr[31:26];
   assign Rs           = r_instr[25:21];
   assign Rt           = r_instr[20:16];
   assign Rd           = r_instr[15:11];
   assign Funct        = r_instr[5:0];
   assign SignImm      = {{(WIDTH-16){r_instr[15]}}, r_instr[15:0]};
   assign SignImmSh    = {SignImm[WIDTH-3:0], 2'b00};
   assign JumpTarget   = {r_pc[31:28], r_instr[25:0], 2'b00};
   assign InstRet      = r_instret;
   assign PCMisaligned = r_pc_mis;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Scoreboard bench for mc_datapath_regs: a driver steps a behavioural model
// and queues expected state; a monitor compares after every rising edge.
module tb_mc_datapath_regs;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        IRWrite = 0, PCWrite = 0, Branch = 0, IorD = 0, Zero = 0;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] ULAResult = 0, MemRData = 0, RD1 = 0, RD2 = 0;
   logic [31:0] PC, Instr, Data, A, B, ULAOut, MemAdr, SignImm, SignImmSh, JumpTarget, InstRet;
   logic [5:0]  Op, Funct;
   logic [4:0]  Rs, Rt, Rd;
   logic        PCMisaligned;

   mc_datapath_regs #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
      .IorD(IorD), .PCSrc(PCSrc), .Zero(Zero), .ULAResult(ULAResult),
      .MemRData(MemRData), .RD1(RD1), .RD2(RD2), .PC(PC), .Instr(Instr),
      .Data(Data), .A(A), .B(B), .ULAOut(ULAOut), .MemAdr(MemAdr), .Op(Op),
      .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .SignImm(SignImm),
      .SignImmSh(SignImmSh), .JumpTarget(JumpTarget), .InstRet(InstRet),
      .PCMisaligned(PCMisaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, instr, data, a, b, ulaout, memadr, instret;
      logic        mis;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_ulaout, m_instret;
   logic        m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_instr = 0; m_data = 0; m_a = 0; m_b = 0;
      m_ulaout = 0; m_instret = 0; m_mis = 0;
   endtask

   task automatic check_state(input string tag, input exp_t e);
      int si;
      si = $signed(e.instr[15:0]);
      chk({tag, ".PC"},        PC,           e.pc);
      chk({tag, ".Instr"},     Instr,        e.instr);
      chk({tag, ".Data"},      Data,         e.data);
      chk({tag, ".A"},         A,            e.a);
      chk({tag, ".B"},         B,            e.b);
      chk({tag, ".ULAOut"},    ULAOut,       e.ulaout);
      chk({tag, ".MemAdr"},    MemAdr,       e.memadr);
      chk({tag, ".InstRet"},   InstRet,      e.instret);
      chk({tag, ".PCMis"},     {31'd0, PCMisaligned}, {31'd0, e.mis});
      chk({tag, ".Op"},        {26'd0, Op},    e.instr / 32'h0400_0000);
      chk({tag, ".Funct"},     {26'd0, Funct}, e.instr % 64);
      chk({tag, ".Rs"},        {27'd0, Rs},    (e.instr / 32'h0020_0000) % 32);
      chk({tag, ".Rt"},        {27'd0, Rt},    (e.instr / 32'h0001_0000) % 32);
      chk({tag, ".Rd"},        {27'd0, Rd},    (e.instr / 32'h0000_0800) % 32);
      chk({tag, ".SignImm"},   SignImm,      32'(si));
      chk({tag, ".SignImmSh"}, SignImmSh,    32'(si * 4));
      chk({tag, ".JumpTgt"},   JumpTarget,
          (e.pc & 32'hF000_0000) | ((e.instr & 32'h03FF_FFFF) * 4));
   endtask

   function automatic exp_t snap(input logic iord);
      exp_t e;
      e.pc = m_pc; e.instr = m_instr; e.data = m_data; e.a = m_a; e.b = m_b;
      e.ulaout = m_ulaout; e.instret = m_instret; e.mis = m_mis;
      e.memadr = iord ? m_ulaout : m_pc;
      return e;
   endfunction

   // Drive one cycle at the falling edge and queue the state expected after the next rising edge.
   task automatic drive(input logic rstv, input logic irw, input logic pcw, input logic br,
                        input logic iord, input logic [1:0] src, input logic z,
                        input logic [31:0] ures, input logic [31:0] mrd,
                        input logic [31:0] r1, input logic [31:0] r2);
      logic [31:0] nxt;
      logic        taken;
      @(negedge clk);
      rst = rstv; IRWrite = irw; PCWrite = pcw; Branch = br; IorD = iord;
      PCSrc = src; Zero = z; ULAResult = ures; MemRData = mrd; RD1 = r1; RD2 = r2;
      if (!rstv) begin
         model_reset();
      end else begin
         if (src == 2'd0)      nxt = ures;
         else if (src == 2'd1) nxt = m_ulaout;
         else if (src == 2'd2) nxt = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
         else                  nxt = m_pc;
         taken = (pcw || (br && z)) && (src != 2'd3);
         if (irw) m_instr = mrd;
         m_data = mrd; m_a = r1; m_b = r2; m_ulaout = ures;
         if (taken) begin
            m_pc = nxt;
            m_instret = m_instret + 1;
            if (nxt % 4 != 0) m_mis = 1'b1;
         end
      end
      q.push_back(snap(iord));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            txn++;
            check_state($sformatf("txn%0d", txn), e);
            $display("txn %0d: PC=%h Instr=%h ULAOut=%h MemAdr=%h InstRet=%0d mis=%0b",
                     txn, PC, Instr, ULAOut, MemAdr, InstRet, PCMisaligned);
         end
      end
   end

   initial begin : stim
      logic [31:0] r;
      #1 rst = 1'b0;
      #1;
      model_reset();
      check_state("reset0", snap(1'b0));

      drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h0, $urandom, $urandom, $urandom);           // PC <- 0
      drive(1, 1, 1, 0, 0, 2'd0, 0, 32'h4, 32'h2008_0005, $urandom, $urandom);      // fetch
      drive(1, 0, 0, 0, 0, 2'd0, 0, 32'h20, $urandom, $urandom, $urandom);          // ULAOut <- 0x20
      drive(1, 0, 0, 1, 0, 2'd1, 1, 32'h20, $urandom, $urandom, $urandom);          // beq taken
      drive(1, 0, 0, 1, 0, 2'd1, 0, 32'h44, $urandom, $urandom, $urandom);          // beq not taken
      drive(1, 1, 1, 0, 0, 2'd0, 0, 32'hA000_0010, 32'h0800_0040, $urandom, $urandom);
      drive(1, 0, 1, 0, 0, 2'd2, 0, $urandom, $urandom, $urandom, $urandom);        // jump
      drive(1, 0, 0, 0, 1, 2'd0, 0, 32'h0000_0104, $urandom, $urandom, $urandom);   // IorD
      drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h6, $urandom, $urandom, $urandom);           // misaligned
      drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h8, $urandom, $urandom, $urandom);           // sticky
      drive(1, 0, 1, 0, 0, 2'd3, 0, $urandom, $urandom, $urandom, $urandom);        // hold
      drive(1, 0, 0, 0, 0, 2'd0, 0, 32'h10, 32'h0, 32'h0, 32'h0);                   // idle

      @(posedge clk);
      #2;
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      m_instret = 32'hFFFF_FFFF;
      drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h10, 32'h0, 32'h0, 32'h0);                   // wrap

      repeat (60) begin
         r = $urandom;
         drive(1, r[0], r[1] & r[2], r[3], r[4], r[6:5], r[7],
               r[8] ? $urandom : ($urandom & 32'hFFFF_FFFC), $urandom, $urandom, $urandom);
      end

      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_state("async_rst", snap(IorD));
      drive(0, 1, 1, 1, 0, 2'd0, 1, $urandom, $urandom, $urandom, $urandom);        // blocked in reset
      drive(1, 1, 1, 0, 0, 2'd0, 0, 32'h0000_0100, 32'h8C08_FFFC, $urandom, $urandom);
      repeat (20) begin
         r = $urandom;
         drive(1, r[0], r[1], r[3], r[4], r[6:5], r[7],
               $urandom & 32'hFFFF_FFFC, $urandom, $urandom, $urandom);
      end

      repeat (4) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Sequential register bank of the multicycle MIPS datapath, directly downstream of the multicycle control unit. It holds the architectural PC and the non-architectural registers: IR, memory data register, A/B operand latches and ULAOut. It also generates the PC-enable, the next-PC mux, the memory address mux and the decoded instruction fields that feed the controller (Op, Funct) and the register file. Two status outputs are included: a retired-instruction counter and a sticky misaligned-PC flag.

## Interface
- WIDTH, 32, datapath width; fixed at 32 for the jump-target format.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 forces reset state immediately.
- IRWrite, PCWrite, Branch, IorD  in  1 each  controller strobes.
- PCSrc  in  2  next-PC select.
- Zero  in  1  ULA zero flag (combinational, current cycle).
- ULAResult  in  WIDTH  ULA output, current cycle.
- MemRData  in  WIDTH  memory read data for address MemAdr.
- RD1, RD2  in  WIDTH  register file read ports.
- PC, Instr, Data, A, B, ULAOut  out  WIDTH  register contents.
- MemAdr  out  WIDTH  memory address.
- Op, Funct  out  6 each  Instr[31:26], Instr[5:0].
- Rs, Rt, Rd  out  5 each  Instr[25:21], [20:16], [15:11].
- SignImm  out  WIDTH  sign-extended Instr[15:0].
- SignImmSh  out  WIDTH  SignImm << 2.
- JumpTarget  out  WIDTH  {PC[31:28], Instr[25:0], 2'b00}.
- InstRet  out  32  count of PC updates since reset.
- PCMisaligned  out  1  sticky flag.

## Operation
- PCEn = PCWrite | (Branch & Zero).
- PCNext, selected by PCSrc:
  - 00: ULAResult.
  - 01: ULAOut.
  - 10: JumpTarget.
  - 11: PC (hold; treated as no change even if PCEn).
- PC loads PCNext when PCEn = 1 and PCSrc != 11; otherwise PC holds.
- IR loads MemRData on every edge with IRWrite = 1. IRWrite held high across states is legal; the IR simply re-reads MemAdr.
- Data, A, B and ULAOut load MemRData, RD1, RD2 and ULAResult unconditionally on every edge.
- MemAdr = IorD ? ULAOut : PC. Purely combinational, from the current register values.
- All decoded fields, SignImm, SignImmSh and JumpTarget are combinational from the current Instr/PC.
- InstRet increments by 1 on each edge where the PC actually loads. It wraps at 2^32 − 1 → 0 without saturating.
- PCMisaligned sets to 1 on an edge where the PC loads a value with PCNext[1:0] != 00.
  - It clears only on reset.
  - The PC still takes the misaligned value; there is no trap.
- Reset (rst = 0, asynchronous), all at once:
  - PC = RESET_PC.
  - Instr, Data, A, B and ULAOut = 0, so Op = 0 and Funct = 0.
  - InstRet = 0; PCMisaligned = 0.
- While rst = 0, all loads are blocked regardless of strobes.
- Release is synchronous in effect: the first load happens at the first rising edge with rst = 1.

## Timing
- Every register has a 1-cycle latency: inputs sampled at edge N are visible on the outputs after edge N.
- Simultaneous IRWrite and PCEn: the IR captures MemRData addressed by the old PC (MemAdr uses the pre-edge PC), and the PC takes PCNext on the same edge.
- Branch taken: Branch = 1 and Zero = 1 in the same cycle. With PCSrc = 01, the PC takes ULAOut, i.e. the branch target computed in the previous cycle.
- Branch not taken: Zero = 0 with PCWrite = 0 leaves PC and InstRet unchanged.
- Reset asserted mid-instruction: everything returns to reset values within the same cycle. No partial state survives.
- No combinational path runs from the strobes to PC/Instr; MemAdr depends on IorD combinationally.

## Structure
- Shared package mc_pkg:
  - PCSrc encodings PCSRC_ULA, PCSRC_ULAOUT, PCSRC_JUMP, PCSRC_HOLD.
  - Opcode constants R_TYPE, LW, SW, BEQ, ADDI, J as 6-bit binary literals.
  - The WIDTH default.
- One natural sub-module: mc_en_reg, a parameterised flop with async active-low reset, reset value and enable. It is used for PC, IR and the free-running latches (enable tied high).
- Counter and sticky flag stay inline.

## Test plan
- Reset value and async behaviour: assert rst = 0 between edges with RESET_PC = 32'h0040_0000 → PC = 32'h0040_0000 and all other registers 0 immediately, before the next edge.
- Fetch increment: PC = 0, PCWrite = 1, PCSrc = 00, ULAResult = 4, IRWrite = 1, MemRData = 32'h2008_0005 → after the edge PC = 4, Instr = 32'h2008_0005, Op = 6'b001000, Rt = 8, SignImm = 5, InstRet = 1.
- Branch taken vs not taken, with ULAOut = 32'h0000_0020, Branch = 1, PCSrc = 01:
  - Zero = 1 → PC = 32'h20.
  - Zero = 0 → PC unchanged, InstRet unchanged.
- Jump: PC = 32'hA000_0010, Instr = 32'h0800_0040, PCSrc = 10, PCWrite = 1 → PC = 32'hA000_0100.
- Address mux and misalignment:
  - IorD = 1, ULAOut = 32'h0000_0104 → MemAdr = 32'h104.
  - PCWrite with ULAResult = 32'h6 → PC = 6, PCMisaligned = 1, still 1 after a later aligned load.
- Counter wrap: force InstRet = 32'hFFFF_FFFF and do one PC load → InstRet = 0.
- PCSrc = 11 with PCWrite = 1 → PC and InstRet unchanged.
